// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg: definitions shared by the IF->ID stage latch and its response FIFO.
//   - IF_FLUSH macro: the stage is flushed by an exception or a branch redirect.
//   - lane_pld_t: layout of one 64-bit lane payload (field offsets).
//   - cancel_width(): counter width needed to hold 0..cancel_max.
// ----------------------------------------------------------------------------
`ifndef IF_PKG_SV
`define IF_PKG_SV

`define IF_FLUSH(excep, branch) ((excep) | (branch))

package if_pkg;

    // Lane payload layout, LSB first: pc[31:0], excep_en[32], excep_type[38:33].
    typedef struct packed {
        logic [24:0] rsvd;
        logic [5:0]  excep_type;
        logic        excep_en;
        logic [31:0] pc;
    } lane_pld_t;

    localparam int LANE_PC_LSB         = 0;
    localparam int LANE_EXCEP_EN_BIT   = 32;
    localparam int LANE_EXCEP_TYPE_LSB = 33;

    function automatic int cancel_width(input int cancel_max);
        return $clog2(cancel_max + 1);
    endfunction

endpackage

`endif

// File: rtl/if_resp_fifo.sv
// ----------------------------------------------------------------------------
// if_resp_fifo: small FIFO holding instruction-RAM responses while IF stalls.
//   clk, rst_n   clock, synchronous active-low reset
//   push, wdata  write request (dropped and flagged when full without a pop)
//   pop          consume head; ignored when empty or during flush
//   flush        empty the FIFO; a pop in the same cycle is ignored
//   rdata        head entry, combinational
//   empty, full  occupancy flags derived from pointers with an extra MSB
//   ovf_err      sticky overflow flag, cleared only by reset
// ----------------------------------------------------------------------------
module if_resp_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic         ovf_err
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    assign do_pop  = pop & ~empty & ~flush;
    // When full, a simultaneous pop frees the slot being written this edge.
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !do_pop) ovf_err <= 1'b1;
        end
    end

    // NOTE: storage has no reset; entries are only ever read behind a valid
    // pointer, so clearing them would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_stage_latch_mq.sv
// ----------------------------------------------------------------------------
// if_stage_latch_mq: IF->ID stage latch for an N-lane fetch pipeline.
//   clk, rst_n          clock, synchronous active-low reset
//   pre_valid_i         per-lane valid from pre-IF; lane0 gates the handshake
//   pre_lane_i          per-lane payload, lane k at [k*LANE_W +: LANE_W]
//   pre_common_i        payload shared by all lanes
//   ready_go_i          this stage has finished its work
//   next_allowin_i      decode queue can accept
//   allowin_o           this stage can accept from pre-IF
//   valid_o, lane_o,
//   common_o            registered stage contents
//   excep_flush_i,
//   branch_flush_i      flush sources
//   cancel_add_i        outstanding responses to kill, sampled on a flush
//   resp_valid_i,
//   resp_data_i         instruction RAM response
//   rbuf_pop_i          consume response FIFO head
//   rbuf_valid_o/data_o/full_o  response FIFO status and head
//   cancel_cnt_o/busy_o pending cancel count and non-zero flag
//   ovf_err_o           sticky response FIFO overflow
// ----------------------------------------------------------------------------
module if_stage_latch_mq
    import if_pkg::*;
#(
    parameter  int LANES      = 2,
    parameter  int LANE_W     = 64,
    parameter  int COMMON_W   = 8,
    parameter  int RDATA_W    = 65,
    parameter  int BUF_DEPTH  = 2,
    parameter  int CANCEL_MAX = 3,
    localparam int CANCEL_W   = cancel_width(CANCEL_MAX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          pre_valid_i,
    input  logic [LANES*LANE_W-1:0]   pre_lane_i,
    input  logic [COMMON_W-1:0]       pre_common_i,
    input  logic                      ready_go_i,
    input  logic                      next_allowin_i,
    output logic                      allowin_o,
    output logic [LANES-1:0]          valid_o,
    output logic [LANES*LANE_W-1:0]   lane_o,
    output logic [COMMON_W-1:0]       common_o,
    input  logic                      excep_flush_i,
    input  logic                      branch_flush_i,
    input  logic [CANCEL_W-1:0]       cancel_add_i,
    input  logic                      resp_valid_i,
    input  logic [RDATA_W-1:0]        resp_data_i,
    input  logic                      rbuf_pop_i,
    output logic                      rbuf_valid_o,
    output logic [RDATA_W-1:0]        rbuf_data_o,
    output logic                      rbuf_full_o,
    output logic [CANCEL_W-1:0]       cancel_cnt_o,
    output logic                      cancel_busy_o,
    output logic                      ovf_err_o
);

    logic                flush;
    logic                load;
    logic                resp_push;
    logic                fifo_empty;
    logic [CANCEL_W-1:0] cnt_next;
    int                  cnt_sum;

    assign flush     = `IF_FLUSH(excep_flush_i, branch_flush_i);
    assign allowin_o = ~valid_o[0] | (ready_go_i & next_allowin_i);
    assign load      = allowin_o & pre_valid_i[0] & ~flush;

    // ---------------- stage register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_o  <= '0;
            lane_o   <= '0;
            common_o <= '0;
        end else begin
            // Flush wins over a load arriving in the same cycle.
            if (flush)          valid_o <= '0;
            else if (allowin_o) valid_o <= pre_valid_i;
            if (load) begin
                lane_o   <= pre_lane_i;
                common_o <= pre_common_i;
            end
        end
    end

    // ---------------- cancel counter ----------------
    assign cancel_busy_o = (cancel_cnt_o != '0);

    // NOTE: cnt_sum is a temporary built up step by step within this block,
    // so blocking assignments are required; registers below use <=.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch,
        // so no path can leave it unassigned and infer a latch.
        cnt_sum  = int'(cancel_cnt_o) - int'(resp_valid_i & cancel_busy_o);
        cnt_next = cancel_cnt_o;
        if (flush) cnt_sum = cnt_sum + int'(cancel_add_i);
        if (cnt_sum > CANCEL_MAX) cnt_next = CANCEL_W'(CANCEL_MAX);
        else if (cnt_sum < 0)     cnt_next = '0;
        else                      cnt_next = CANCEL_W'(cnt_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cancel_cnt_o <= '0;
        else        cancel_cnt_o <= cnt_next;
    end

    // ---------------- response routing ----------------
    // Responses to requests killed by an earlier flush are swallowed while the
    // counter is non-zero; one arriving in the flush cycle itself is dropped too.
    assign resp_push = resp_valid_i & ~cancel_busy_o & ~flush;

    if_resp_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (RDATA_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (resp_push),
        .wdata   (resp_data_i),
        .pop     (rbuf_pop_i),
        .flush   (flush),
        .rdata   (rbuf_data_o),
        .empty   (fifo_empty),
        .full    (rbuf_full_o),
        .ovf_err (ovf_err_o)
    );

    assign rbuf_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_if_stage_latch_mq.sv
module tb_if_stage_latch_mq;

    localparam int LANES      = 2;
    localparam int LANE_W     = 64;
    localparam int COMMON_W   = 8;
    localparam int RDATA_W    = 65;
    localparam int BUF_DEPTH  = 2;
    localparam int CANCEL_MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    pre_valid;
    logic [127:0]  pre_lane;
    logic [7:0]    pre_common;
    logic          ready_go, next_allowin, excep_flush, branch_flush;
    logic [1:0]    cancel_add;
    logic          resp_valid;
    logic [64:0]   resp_data;
    logic          rbuf_pop;

    logic          allowin_o;
    logic [1:0]    valid_o;
    logic [127:0]  lane_o;
    logic [7:0]    common_o;
    logic          rbuf_valid_o, rbuf_full_o, cancel_busy_o, ovf_err_o;
    logic [64:0]   rbuf_data_o;
    logic [1:0]    cancel_cnt_o;

    always #5 clk = ~clk;

    if_stage_latch_mq #(
        .LANES(LANES), .LANE_W(LANE_W), .COMMON_W(COMMON_W), .RDATA_W(RDATA_W),
        .BUF_DEPTH(BUF_DEPTH), .CANCEL_MAX(CANCEL_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_valid_i(pre_valid), .pre_lane_i(pre_lane), .pre_common_i(pre_common),
        .ready_go_i(ready_go), .next_allowin_i(next_allowin),
        .allowin_o(allowin_o), .valid_o(valid_o), .lane_o(lane_o), .common_o(common_o),
        .excep_flush_i(excep_flush), .branch_flush_i(branch_flush),
        .cancel_add_i(cancel_add),
        .resp_valid_i(resp_valid), .resp_data_i(resp_data), .rbuf_pop_i(rbuf_pop),
        .rbuf_valid_o(rbuf_valid_o), .rbuf_data_o(rbuf_data_o), .rbuf_full_o(rbuf_full_o),
        .cancel_cnt_o(cancel_cnt_o), .cancel_busy_o(cancel_busy_o), .ovf_err_o(ovf_err_o)
    );

    // Expected visible state for one cycle, and one instruction group leaving the stage.
    typedef struct {
        logic         allowin;
        logic [1:0]   valid;
        logic [127:0] lane;
        logic [7:0]   common;
        logic         rbuf_valid;
        logic         rbuf_full;
        logic [1:0]   cnt;
        logic         ovf;
    } status_t;

    typedef struct {
        logic [1:0]   valid;
        logic [127:0] lane;
        logic [7:0]   common;
    } item_t;

    status_t     status_q[$];
    item_t       item_q[$];
    logic [64:0] fifo_q[$];

    // Reference model: occupancy of the stage, last accepted payload,
    // FIFO contents as a queue, cancel count as an integer.
    logic [1:0]   m_valid;
    logic [127:0] m_lane;
    logic [7:0]   m_common;
    int           m_cnt;
    logic         m_ovf;
    bit           m_known = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic set_idle();
        pre_valid    = '0;
        pre_lane     = '0;
        pre_common   = '0;
        ready_go     = 1'b1;
        next_allowin = 1'b1;
        excep_flush  = 1'b0;
        branch_flush = 1'b0;
        cancel_add   = '0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        rbuf_pop     = 1'b0;
    endtask

    // Issue the current inputs for one clock: record what the DUT must show
    // this cycle, advance the model across the edge, then wait the edge.
    task automatic cycle();
        bit      fl, al, pop_ok;
        int      nxt;
        status_t s;
        item_t   it;
        if (!rst_n) begin
            m_valid  = '0;
            m_lane   = '0;
            m_common = '0;
            m_cnt    = 0;
            m_ovf    = 1'b0;
            m_known  = 1'b1;
            fifo_q.delete();
            item_q.delete();
            status_q.delete();
        end else if (m_known) begin
            fl = excep_flush || branch_flush;
            al = !m_valid[0] || (ready_go && next_allowin);
            s.allowin    = al;
            s.valid      = m_valid;
            s.lane       = m_lane;
            s.common     = m_common;
            s.rbuf_valid = (fifo_q.size() != 0);
            s.rbuf_full  = (fifo_q.size() == BUF_DEPTH);
            s.cnt        = m_cnt[1:0];
            s.ovf        = m_ovf;
            status_q.push_back(s);

            if (fl) item_q.delete();
            if (!fl && al && pre_valid[0]) begin
                m_lane   = pre_lane;
                m_common = pre_common;
                it.valid  = pre_valid;
                it.lane   = pre_lane;
                it.common = pre_common;
                item_q.push_back(it);
            end
            if (fl)      m_valid = '0;
            else if (al) m_valid = pre_valid;

            pop_ok = rbuf_pop && (fifo_q.size() != 0) && !fl;
            if (fl) fifo_q.delete();
            else if (resp_valid && m_cnt == 0) begin
                if (fifo_q.size() < BUF_DEPTH || pop_ok) fifo_q.push_back(resp_data);
                else m_ovf = 1'b1;
            end

            nxt = m_cnt + (fl ? int'(cancel_add) : 0) - ((resp_valid && m_cnt != 0) ? 1 : 0);
            if (nxt > CANCEL_MAX) nxt = CANCEL_MAX;
            if (nxt < 0) nxt = 0;
            m_cnt = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the per-cycle status, each group handed to decode,
    // and each FIFO entry consumed.
    always @(negedge clk) begin : monitor
        status_t     s;
        item_t       it;
        logic [64:0] d;
        if (rst_n && status_q.size() > 0) begin
            s = status_q.pop_front();
            check("allowin",     128'(allowin_o),     128'(s.allowin));
            check("valid",       128'(valid_o),       128'(s.valid));
            check("lane",        lane_o,              s.lane);
            check("common",      128'(common_o),      128'(s.common));
            check("rbuf_valid",  128'(rbuf_valid_o),  128'(s.rbuf_valid));
            check("rbuf_full",   128'(rbuf_full_o),   128'(s.rbuf_full));
            check("cancel_cnt",  128'(cancel_cnt_o),  128'(s.cnt));
            check("cancel_busy", 128'(cancel_busy_o), 128'(s.cnt != 0));
            check("ovf_err",     128'(ovf_err_o),     128'(s.ovf));
        end
        if (rst_n && m_known && !(excep_flush || branch_flush)) begin
            if (valid_o[0] && ready_go && next_allowin) begin
                if (item_q.size() == 0) begin
                    n_total++;
                    $display("FAIL stage_out: actual=unexpected group required=none");
                end else begin
                    it = item_q.pop_front();
                    check("out_valid",  128'(valid_o),  128'(it.valid));
                    check("out_lane",   lane_o,         it.lane);
                    check("out_common", 128'(common_o), 128'(it.common));
                end
            end
            if (rbuf_valid_o && rbuf_pop) begin
                if (fifo_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rbuf_pop: actual=unexpected entry required=none");
                end else begin
                    d = fifo_q.pop_front();
                    check("rbuf_data", 128'(rbuf_data_o), 128'(d));
                end
            end
        end
    end

    logic [127:0] held_lane;

    initial begin
        set_idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        check("reset_valid", 128'(valid_o), 128'(0));
        check("reset_cnt",   128'(cancel_cnt_o), 128'(0));

        // 1: both lanes accepted with 1-cycle latency, allowin stays high.
        pre_valid  = 2'b11;
        pre_lane   = {64'h1C000004, 64'h1C000000};
        pre_common = 8'h5A;
        cycle();
        check("t1_valid",   128'(valid_o),   128'(2'b11));
        check("t1_lane",    lane_o,          {64'h1C000004, 64'h1C000000});
        check("t1_allowin", 128'(allowin_o), 128'(1));

        // 2: lane0-only group, then stall for 3 cycles while inputs change.
        pre_valid = 2'b01;
        pre_lane  = {64'h0, 64'h1C000008};
        cycle();
        held_lane    = pre_lane;
        next_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pre_valid = 2'b11;
            pre_lane  = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
            check("t2_allowin", 128'(allowin_o), 128'(0));
            check("t2_valid",   128'(valid_o),   128'(2'b01));
            check("t2_lane",    lane_o,          held_lane);
        end
        set_idle();
        cycle();

        // 3: flush killing 2 responses; the third is kept.
        excep_flush = 1'b1;
        cancel_add  = 2'd2;
        cycle();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp_data  = 65'h1_0000_0000_0000_00A0 + 65'(i);
            cycle();
        end
        set_idle();
        check("t3_rbuf_valid", 128'(rbuf_valid_o), 128'(1));
        check("t3_rbuf_data",  128'(rbuf_data_o),  128'(65'h1_0000_0000_0000_00A2));

        // 4: cnt=1, then flush add=3 with a response in the same cycle.
        branch_flush = 1'b1;
        cancel_add   = 2'd1;
        cycle();
        branch_flush = 1'b1;
        cancel_add   = 2'd3;
        resp_valid   = 1'b1;
        resp_data    = 65'h0DEAD;
        cycle();
        set_idle();
        check("t4_cnt",        128'(cancel_cnt_o), 128'(3));
        check("t4_rbuf_valid", 128'(rbuf_valid_o), 128'(0));
        resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        set_idle();

        // 5: fill, push+pop while full, then overflow.
        resp_valid = 1'b1;
        resp_data  = 65'h111;
        cycle();
        resp_data  = 65'h222;
        cycle();
        check("t5_full", 128'(rbuf_full_o), 128'(1));
        resp_data = 65'h333;
        rbuf_pop  = 1'b1;
        cycle();
        rbuf_pop = 1'b0;
        check("t5_full_after_pp", 128'(rbuf_full_o), 128'(1));
        check("t5_head",          128'(rbuf_data_o), 128'(65'h222));
        check("t5_no_ovf",        128'(ovf_err_o),   128'(0));
        resp_data = 65'h444;
        cycle();
        set_idle();
        cycle();
        check("t5_ovf", 128'(ovf_err_o), 128'(1));

        // 6: reset mid-run with a loaded stage, full FIFO and sticky overflow;
        // then again with a pending cancel count.
        pre_valid = 2'b11;
        pre_lane  = {64'h55, 64'h66};
        cycle();
        set_idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("t6_valid", 128'(valid_o),      128'(0));
        check("t6_empty", 128'(rbuf_valid_o), 128'(0));
        check("t6_ovf",   128'(ovf_err_o),    128'(0));
        excep_flush = 1'b1;
        cancel_add  = 2'd2;
        cycle();
        set_idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("t6_cnt", 128'(cancel_cnt_o), 128'(0));

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 499) != 0);
            pre_valid    = 2'($urandom());
            pre_lane     = {$urandom(), $urandom(), $urandom(), $urandom()};
            pre_common   = 8'($urandom());
            ready_go     = ($urandom_range(0, 3) != 0);
            next_allowin = ($urandom_range(0, 3) != 0);
            excep_flush  = ($urandom_range(0, 15) == 0);
            branch_flush = ($urandom_range(0, 15) == 0);
            cancel_add   = 2'($urandom());
            resp_valid   = ($urandom_range(0, 1) == 1);
            resp_data    = {1'($urandom()), $urandom(), $urandom()};
            rbuf_pop     = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst_n = 1'b1;
        set_idle();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
